// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word fall-through byte FIFO on a valid/ready port.
// Reports framing errors, a held-low line (break) and FIFO overflow.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              frame_err,
    output logic              overflow,
    output logic              line_break
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [2:0]        idx, idx_nx;
    logic [7:0]        shreg, shreg_nx;
    logic              rx_meta, rx_s;
    logic              push, frame_err_nx;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              full, pop, wr_en, overflow_nx;

    // Two-flop synchronizer; idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_nx;
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt + CNT_W'(1);
        idx_nx       = idx;
        shreg_nx     = shreg;
        push         = 1'b0;
        frame_err_nx = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (!rx_s) state_nx = S_START;
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx        = '0;
                    shreg_nx[idx] = rx_s;
                    if (idx == 3'd7) state_nx = S_STOP;
                    else             idx_nx   = idx + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        push     = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A line stuck low must not be re-read as a stream of zero bytes.
                cnt_nx = '0;
                if (rx_s) state_nx = S_IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    assign line_break = (state == S_BREAK);

    assign out_valid   = (count != '0);
    assign full        = (count == (ADDR_W + 1)'(DEPTH));
    assign pop         = out_valid && out_ready;
    // When full, a same-cycle pop frees the head slot, which is exactly wr_ptr.
    assign wr_en       = push && (!full || pop);
    assign overflow_nx = push && full && !pop;
    assign out_data    = out_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= frame_err_nx;
            overflow  <= overflow_nx;
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames in, bytes compared against a queue model.
module tb_uart_rx_fifo;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    logic [AW:0]   count;
    logic          frame_err;
    logic          overflow;
    logic          line_break;

    logic          ready_man  = 1'b0;
    logic          rand_ready = 1'b0;
    logic          rnd_bit    = 1'b0;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    exp_q[$];
    int            exp_ferr = 0, exp_ovf = 0;
    int            ferr_seen = 0, ovf_seen = 0;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         exp_err;
    } vec_t;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .frame_err(frame_err), .overflow(overflow),
        .line_break(line_break)
    );

    always #5 clk = ~clk;

    assign out_ready = rand_ready ? rnd_bit : ready_man;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted byte must be the oldest one the model still owes.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (frame_err) ferr_seen++;
            if (overflow)  ovf_seen++;
            if (frame_err && overflow) check("err_exclusive", 1, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("pop_unexpected", {24'd0, out_data}, 32'hFFFF_FFFF);
                else                   check("pop_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame a byte on rx; the model decides up front what the receiver must produce.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)                  exp_ferr++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                           exp_ovf++;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic do_reset(input logic rx_val);
        rst_n = 1'b0;
        rx    = rx_val;
        #1;
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
    endtask

    vec_t vecs[6];
    int   base;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 1'b1, 0};
        vecs[1] = '{8'hFF, 1'b1, 0};
        vecs[2] = '{8'h3C, 1'b1, 0};
        vecs[3] = '{8'h81, 1'b1, 0};
        vecs[4] = '{8'h42, 1'b0, 1};
        vecs[5] = '{8'hC3, 1'b1, 0};

        rst_n = 1'b0;
        rx    = 1'b1;
        tick(3);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", count, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
        check("rst_break", line_break, 0);
        rst_n = 1'b1;
        tick(4);

        // Single byte with exact push latency.
        fork
            send_byte(8'hA5, 1'b1);
            begin
                repeat (40) @(posedge clk);
                @(negedge clk);
                check("lat_before", out_valid, 0);
                @(negedge clk);
                check("lat_after", out_valid, 1);
            end
        join
        check("t1_data", out_data, 8'hA5);
        check("t1_count", count, 1);
        ready_man = 1'b1;
        tick(1);
        ready_man = 1'b0;
        check("t1_count_drained", count, 0);
        check("t1_valid_drained", out_valid, 0);

        // Table vectors with consumer always ready.
        ready_man = 1'b1;
        foreach (vecs[i]) begin
            base = ferr_seen;
            send_byte(vecs[i].data, vecs[i].stop_ok);
            check("tbl_ferr", ferr_seen - base, vecs[i].exp_err);
            check("tbl_count", count, 0);
        end
        check("tbl_ovf", ovf_seen, 0);
        ready_man = 1'b0;

        // Five bytes into a four-deep FIFO.
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b1);
        check("ovf_count", count, DEPTH);
        check("ovf_pulses", ovf_seen, exp_ovf);
        check("ovf_head", out_data, 8'h10);
        ready_man = 1'b1;
        tick(6);
        ready_man = 1'b0;
        check("ovf_drained", count, 0);
        check("ovf_model_empty", exp_q.size(), 0);

        // Line held low from reset release.
        do_reset(1'b0);
        tick(200);
        exp_ferr++;
        check("brk_ferr", ferr_seen, exp_ferr);
        check("brk_level", line_break, 1);
        check("brk_count", count, 0);
        rx = 1'b1;
        tick(4);
        check("brk_clear", line_break, 0);
        send_byte(8'h5A, 1'b1);
        check("brk_after_data", out_data, 8'h5A);
        ready_man = 1'b1;
        tick(2);
        ready_man = 1'b0;

        // One-clock glitch.
        base = ferr_seen;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(50);
        check("glitch_count", count, 0);
        check("glitch_ferr", ferr_seen - base, 0);
        check("glitch_break", line_break, 0);

        // Randomized bytes with a randomly stalling consumer.
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        rand_ready = 1'b0;
        ready_man  = 1'b1;
        tick(6);
        ready_man  = 1'b0;
        check("rand_count", count, 0);
        check("rand_model_empty", exp_q.size(), 0);
        check("ferr_total", ferr_seen, exp_ferr);
        check("ovf_total", ovf_seen, exp_ovf);

        // Reset mid-frame with bytes queued.
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("mid_count_before", count, 2);
        rx = 1'b0;
        tick(CPB + 2 * CPB);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_break", line_break, 0);
        exp_q.delete();
        rx = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        send_byte(8'h77, 1'b1);
        check("mid_after_count", count, 1);
        check("mid_after_data", out_data, 8'h77);
        ready_man = 1'b1;
        tick(2);
        ready_man = 1'b0;
        check("final_count", count, 0);
        check("final_model_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
